bcd_digit_counter: RTL and testbench
====================================

Name: bcd_digit_counter

Overview:
- Multi-digit packed-BCD up/down counter with synchronous clear and parallel load.
- Sits directly upstream of the BCD-to-Gray converter and drives its bcd input, one 4-bit digit per slice of the count.
- The output register uses a valid/ready handshake so downstream stages can stall the count.
- Every beat carries a wrap flag that marks roll-over or roll-under.

Parameters:
NUM_DIGITS, 2, number of BCD decades; must be at least 1.
BCD_WIDTH, 4, bits per digit; fixed at 4; any other value is unsupported.

Ports:
clk  input  1  sole clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous clear to zero; highest priority.
load  input  1  synchronous parallel load of load_val.
load_val  input  NUM_DIGITS*BCD_WIDTH  packed BCD load value; digit 0 in the LSBs.
en  input  1  count-step request.
up_dn  input  1  1 = increment, 0 = decrement; sampled with en.
bcd_out  output  NUM_DIGITS*BCD_WIDTH  registered packed BCD count.
out_valid  output  1  bcd_out holds a beat not yet consumed.
out_ready  input  1  downstream accepts the current beat.
wrap  output  1  current beat resulted from 99..9→0 (up) or 0→99..9 (down).
load_err  output  1  one-cycle pulse: a load was rejected because a load_val digit was greater than 9.

Behaviour:
- Reset (rst_n low, asynchronous): bcd_out = 0, out_valid = 0, wrap = 0, load_err = 0. Outputs hold these values while rst_n is low. Reset asserted mid-count discards the in-flight beat.
- Advance condition: adv = !out_valid || out_ready, evaluated in the same cycle.
- Priority each cycle: clr > load > en.
  - clr: applied regardless of adv. Result: bcd_out = 0, wrap = 0, out_valid = 1. Any unconsumed beat is overwritten.
  - load with adv, all digits ≤ 9: bcd_out = load_val, wrap = 0, out_valid = 1.
  - load with adv, any digit > 9: count unchanged, load_err = 1 for one cycle. out_valid is cleared if the old beat was consumed this cycle, else held. The load consumes the cycle, so en is ignored.
  - load without adv: ignored, no load_err.
  - en with adv, no clr/load: one step. bcd_out updates on that edge (latency 1), out_valid = 1. wrap = 1 only when the step crossed the full-range boundary, else 0.
  - en without adv: stalled; the count holds and the step is dropped (not queued).
- Increment: digit 0 += 1. A digit equal to 9 becomes 0 and carries into the next digit, rippling combinationally within the cycle. Carry out of the top digit sets wrap.
- Decrement: digit 0 −= 1. A digit equal to 0 becomes 9 and borrows from the next digit. Borrow out of the top digit sets wrap.
- Handshake:
  - out_ready with out_valid and no new update: out_valid drops to 0 on the next edge, and wrap drops with it.
  - Consume and step in the same cycle: out_valid stays 1 and the new value replaces the old.
  - While out_valid = 1 and out_ready = 0: bcd_out and wrap are stable.
- No update when out_valid = 0: bcd_out holds its last value, and downstream may still read it as a level.
- Internal digits never exceed 9 under any input sequence. A non-BCD load_val is never stored.
- load_err does not depend on out_ready and never sets out_valid.

Test Plan:
- NUM_DIGITS=2, reset, out_ready=1, en=1, up_dn=1 for 100 cycles → bcd_out steps 0x01…0x99, then 0x00 with wrap=1 for exactly that beat; 0x09→0x10 carry verified.
- load_val=0x00, load, then en with up_dn=0 → bcd_out=0x99, wrap=1; next step 0x98, wrap=0.
- load_val=0x3A → load_err pulses 1 cycle, bcd_out unchanged, out_valid not set by the load; load_val=0x37 → bcd_out=0x37, out_valid=1.
- out_ready=0 after one step from 0x05 → bcd_out holds 0x06 for 5 cycles while en stays high. Raise out_ready → next edge 0x07, out_valid remains 1.
- clr together with load=1, en=1, out_ready=0, bcd_out=0x42 → bcd_out=0x00, out_valid=1, wrap=0.
- Assert rst_n low asynchronously mid-step (between edges) with out_valid=1 → all outputs 0 immediately; after release, the first en step yields 0x01.

Source files
------------

// File: rtl/bcd_digit_counter.sv
// ----------------------------------------------------------------------------
// bcd_digit_counter
//
// Multi-digit packed-BCD up/down counter. The count is presented on a
// registered valid/ready output, so a stalled downstream stage freezes the
// count. Each beat also carries a wrap flag that marks a full-range roll-over
// (99..9 -> 0) or roll-under (0 -> 99..9).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear to zero (highest priority, ignores stall)
//   load       synchronous parallel load of load_val (only when advancing)
//   load_val   packed BCD load value, digit 0 in the LSBs
//   en         count-step request (dropped, not queued, while stalled)
//   up_dn      step direction: 1 = increment, 0 = decrement
//   bcd_out    registered packed BCD count
//   out_valid  bcd_out holds a beat not yet consumed
//   out_ready  downstream accepts the current beat
//   wrap       current beat came from a full-range roll-over/roll-under
//   load_err   one-cycle pulse: load rejected because a digit was above 9
//
// BCD_WIDTH is fixed at 4; other values are not supported.
// ----------------------------------------------------------------------------
module bcd_digit_counter #(
  parameter int NUM_DIGITS = 2,
  parameter int BCD_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            load,
  input  logic [NUM_DIGITS*BCD_WIDTH-1:0] load_val,
  input  logic                            en,
  input  logic                            up_dn,
  output logic [NUM_DIGITS*BCD_WIDTH-1:0] bcd_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            wrap,
  output logic                            load_err
);

  localparam int W = NUM_DIGITS * BCD_WIDTH;

  logic [W-1:0] cnt_q,   cnt_d;
  logic         valid_q, valid_d;
  logic         wrap_q,  wrap_d;
  logic         err_q,   err_d;

  logic         adv;
  logic         load_ok;
  logic [W:0]   step_res;

  // True when every digit of v is a legal decimal digit.
  function automatic logic bcd_legal(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*BCD_WIDTH +: BCD_WIDTH] > BCD_WIDTH'(9)) ok = 1'b0;
    end
    return ok;
  endfunction

  // One decimal step of the whole count. The carry/borrow ripples from
  // digit 0 upward; the MSB of the result is the carry/borrow out of the top
  // digit, which is exactly the wrap condition.
  function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0]         r;
    logic                 c;
    logic [BCD_WIDTH-1:0] d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[i*BCD_WIDTH +: BCD_WIDTH];
      if (c) begin
        if (up) begin
          if (d == BCD_WIDTH'(9)) begin
            r[i*BCD_WIDTH +: BCD_WIDTH] = '0;
            c = 1'b1;
          end else begin
            r[i*BCD_WIDTH +: BCD_WIDTH] = d + BCD_WIDTH'(1);
            c = 1'b0;
          end
        end else begin
          if (d == '0) begin
            r[i*BCD_WIDTH +: BCD_WIDTH] = BCD_WIDTH'(9);
            c = 1'b1;
          end else begin
            r[i*BCD_WIDTH +: BCD_WIDTH] = d - BCD_WIDTH'(1);
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  assign adv      = !valid_q || out_ready;
  assign load_ok  = bcd_legal(load_val);
  assign step_res = bcd_step(cnt_q, up_dn);

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    wrap_d  = wrap_q;
    err_d   = 1'b0;
    if (clr) begin
      // Overwrites any unconsumed beat, even while stalled.
      cnt_d   = '0;
      wrap_d  = 1'b0;
      valid_d = 1'b1;
    end else if (load) begin
      // A load (accepted or rejected) owns the cycle; en is ignored.
      if (adv) begin
        if (load_ok) begin
          cnt_d   = load_val;
          wrap_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            wrap_d  = 1'b0;
          end
        end
      end
    end else if (en && adv) begin
      cnt_d   = step_res[W-1:0];
      wrap_d  = step_res[W];
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      // Beat consumed with nothing new behind it; count stays as a level.
      valid_d = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bcd_out   = cnt_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
module tb_bcd_digit_counter;

  localparam int ND = 2;
  localparam int W  = ND * 4;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         up_dn;
  logic [W-1:0] bcd_out;
  logic         out_valid;
  logic         out_ready;
  logic         wrap;
  logic         load_err;

  bcd_digit_counter #(.NUM_DIGITS(ND), .BCD_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .en        (en),
    .up_dn     (up_dn),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wrap      (wrap),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int bcd;
    int v;
    int w;
    int e;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: count held as a plain integer 0..99.
  int m_cnt;
  int m_v;
  int m_w;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int to_bcd(input int n);
    return ((n / 10) << 4) | (n % 10);
  endfunction

  // Apply one cycle of inputs: update the model, push the expectation,
  // clock the DUT, then pop and compare just after the edge.
  task automatic cycle(input logic c, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic ud, input logic r);
    int   adv;
    int   hi, lo;
    exp_t x, got;
    clr = c; load = l; load_val = lv; en = e; up_dn = ud; out_ready = r;
    adv = (!m_v || r) ? 1 : 0;
    x.e = 0;
    if (c) begin
      m_cnt = 0; m_w = 0; m_v = 1;
    end else if (l) begin
      if (adv != 0) begin
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        if (hi <= 9 && lo <= 9) begin
          m_cnt = hi * 10 + lo; m_w = 0; m_v = 1;
        end else begin
          x.e = 1;
          if (m_v != 0 && r) begin m_v = 0; m_w = 0; end
        end
      end
    end else if (e && adv != 0) begin
      if (ud) begin
        m_w = (m_cnt == 99) ? 1 : 0;
        m_cnt = (m_cnt + 1) % 100;
      end else begin
        m_w = (m_cnt == 0) ? 1 : 0;
        m_cnt = (m_cnt + 99) % 100;
      end
      m_v = 1;
    end else if (m_v != 0 && r) begin
      m_v = 0; m_w = 0;
    end
    x.bcd = to_bcd(m_cnt);
    x.v   = m_v;
    x.w   = m_w;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      got = sb.pop_front();
      chk("bcd_out",   int'(bcd_out),   got.bcd);
      chk("out_valid", int'(out_valid), got.v);
      chk("wrap",      int'(wrap),      got.w);
      chk("load_err",  int'(load_err),  got.e);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_v = 0; m_w = 0;
    sb.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bcd"},   int'(bcd_out),   0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_wrap"},  int'(wrap),      0);
    chk({tag, "_err"},   int'(load_err),  0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1; out_ready = 1'b0;
    model_reset();
    #2;
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    #2 rst_n = 1'b1;

    // Full up-count range: 01..99, then 00 with wrap on that beat only.
    for (int i = 0; i < 100; i++) cycle(0, 0, 8'h00, 1, 1, 1);
    cycle(0, 0, 8'h00, 1, 1, 1);

    // Roll-under from 00 to 99, then a normal decrement.
    cycle(0, 1, 8'h00, 0, 0, 1);
    cycle(0, 0, 8'h00, 1, 0, 1);
    cycle(0, 0, 8'h00, 1, 0, 1);

    // Illegal load while consuming: error pulse, valid cleared, count kept.
    cycle(0, 1, 8'h3A, 1, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);
    cycle(0, 1, 8'h37, 0, 1, 1);
    // Illegal load while stalled is ignored entirely.
    cycle(0, 1, 8'hA0, 0, 1, 0);
    cycle(0, 1, 8'hA5, 0, 1, 0);

    // Stall: 05 -> 06, hold for 5 cycles with en high, then 07.
    cycle(0, 1, 8'h05, 0, 1, 1);
    cycle(0, 0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1, 1, 0);
    cycle(0, 0, 8'h00, 1, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);

    // Clear beats load and en even while stalled.
    cycle(0, 1, 8'h42, 0, 1, 1);
    cycle(1, 1, 8'h42, 1, 1, 0);
    cycle(0, 0, 8'h00, 0, 1, 1);

    // Mixed random traffic, including illegal loads and stalls.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset between edges with a beat pending.
    cycle(0, 1, 8'h58, 0, 1, 1);
    clr = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_outputs("async_rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    cycle(0, 0, 8'h00, 1, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
